// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers column/row counters, display enable and lock status from sampled HSYNC/VSYNC.
// Define SYNC_ERR_COUNT_EN to add the saturating err_count output.
//   state  | meaning
//   SEARCH | waiting for the first frame start, no length checks
//   VERIFY | counting error-free frames toward lock
//   LOCKED | timing matches, display_enable allowed
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 29,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_enable,
    input  logic        HSYNC,
    input  logic        VSYNC,
    output logic [11:0] X,
    output logic [11:0] Y,
    output logic        display_enable,
    output logic        frame_start,
    output logic        locked,
`ifdef SYNC_ERR_COUNT_EN
    output logic        sync_error,
    output logic [7:0]  err_count
`else
    output logic        sync_error
`endif
);

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
    localparam logic [11:0] H_START  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END    = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [11:0] V_START  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_END    = 12'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [11:0] SAT      = 12'hFFF;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state, state_next;
    logic [3:0]  good_frames, good_next;
    logic        hs_prev, vs_prev, vs_pending, vs_pending_n, line_armed;
    logic [11:0] h_cnt, v_cnt, h_low, v_low;
    logic [11:0] h_cnt_n, v_cnt_n, h_low_n, v_low_n;
    logic        h_fall, h_rise, v_fall, v_rise, fs_hit, checking;
    logic        err_hw, err_line, err_frame, err_vw, err_any;
    logic        h_act_n, v_act_n;

    always_comb begin
        h_fall    = pixel_enable & hs_prev & ~HSYNC;
        h_rise    = pixel_enable & ~hs_prev & HSYNC;
        v_fall    = pixel_enable & vs_prev & ~VSYNC;
        v_rise    = pixel_enable & ~vs_prev & VSYNC;
        fs_hit    = h_fall & (vs_pending | v_fall);
        checking  = (state != SEARCH);
        err_hw    = h_rise & (h_low != H_SYNC_W);
        err_line  = h_fall & checking & line_armed & (h_cnt != H_LAST);
        err_frame = fs_hit & checking & (v_cnt != V_LAST);
        err_vw    = v_rise & (v_low != V_SYNC_W);
        err_any   = err_hw | err_line | err_frame | err_vw;
    end

    always_comb begin
        h_cnt_n      = h_cnt;
        v_cnt_n      = v_cnt;
        h_low_n      = h_low;
        v_low_n      = v_low;
        vs_pending_n = vs_pending;
        if (pixel_enable) begin
            if (h_fall)
                h_cnt_n = '0;
            else if (h_cnt != SAT)
                h_cnt_n = h_cnt + 12'd1;
            if (!HSYNC)
                h_low_n = h_fall ? 12'd1 : ((h_low == SAT) ? h_low : h_low + 12'd1);
            if (fs_hit) begin
                v_cnt_n      = '0;
                vs_pending_n = 1'b0;
            end else begin
                if (h_fall && v_cnt != SAT)
                    v_cnt_n = v_cnt + 12'd1;
                if (v_fall)
                    vs_pending_n = 1'b1;
            end
            // a line start coinciding with the VSYNC edge is the first low line
            if (v_fall)
                v_low_n = h_fall ? 12'd1 : 12'd0;
            else if (h_fall && !VSYNC && v_low != SAT)
                v_low_n = v_low + 12'd1;
        end
        h_act_n = (h_cnt_n >= H_START) && (h_cnt_n <= H_END);
        v_act_n = (v_cnt_n >= V_START) && (v_cnt_n <= V_END);
    end

    always_comb begin
        state_next = state;
        good_next  = good_frames;
        case (state)
            SEARCH: begin
                if (fs_hit) begin
                    state_next = VERIFY;
                    good_next  = '0;
                end
            end
            VERIFY: begin
                if (err_any) begin
                    state_next = SEARCH;
                end else if (fs_hit) begin
                    good_next = good_frames + 4'd1;
                    if (good_frames + 4'd1 == LOCK_N)
                        state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (err_any)
                    state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= SEARCH;
            good_frames    <= '0;
            hs_prev        <= 1'b1;
            vs_prev        <= 1'b1;
            vs_pending     <= 1'b0;
            line_armed     <= 1'b0;
            h_cnt          <= '0;
            v_cnt          <= '0;
            h_low          <= '0;
            v_low          <= '0;
            X              <= '0;
            Y              <= '0;
            display_enable <= 1'b0;
            frame_start    <= 1'b0;
            sync_error     <= 1'b0;
        end else begin
            state       <= state_next;
            good_frames <= good_next;
            vs_pending  <= vs_pending_n;
            h_cnt       <= h_cnt_n;
            v_cnt       <= v_cnt_n;
            h_low       <= h_low_n;
            v_low       <= v_low_n;
            if (pixel_enable) begin
                hs_prev <= HSYNC;
                vs_prev <= VSYNC;
            end
            // the line that ends the SEARCH->VERIFY transition may be partial
            if (state == SEARCH || state_next == SEARCH)
                line_armed <= 1'b0;
            else if (h_fall)
                line_armed <= 1'b1;
            X              <= h_act_n ? (h_cnt_n - H_START) : '0;
            Y              <= v_act_n ? (v_cnt_n - V_START) : '0;
            display_enable <= (state_next == LOCKED) & h_act_n & v_act_n;
            frame_start    <= fs_hit;
            sync_error     <= err_any;
        end
    end

    assign locked = (state == LOCKED);

`ifdef SYNC_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (state != LOCKED && state_next == LOCKED)
            err_count <= '0;
        else if (err_any && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed table-driven bench for vga_sync_decoder on a scaled-down 40x20 raster.
module tb_vga_sync_decoder;
    localparam int HT = 40, HS = 4, HB = 6, HA = 24;
    localparam int VT = 20, VS = 2, VB = 3, VA = 12;

    logic        clk = 1'b0;
    logic        reset, pixel_enable, HSYNC, VSYNC;
    logic [11:0] X, Y;
    logic        display_enable, frame_start, locked, sync_error;
`ifdef SYNC_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int n_pass = 0, n_total = 0;
    int gh = 0, gv = 0, lh = 0, lv = 0;
    int hs_w = HS, short_v = -1;
    bit vs_mid = 1'b0, slow = 1'b0;
    int n_err = 0, n_fs = 0, hold_bad = 0;

    typedef struct { int v; int h; int x; int y; int de; } vec_t;
    vec_t vecs[12];

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pixel_enable(pixel_enable),
        .HSYNC(HSYNC),
        .VSYNC(VSYNC),
        .X(X),
        .Y(Y),
        .display_enable(display_enable),
        .frame_start(frame_start),
        .locked(locked),
`ifdef SYNC_ERR_COUNT_EN
        .sync_error(sync_error),
        .err_count(err_count)
`else
        .sync_error(sync_error)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit vs_low(input int v, input int h);
        if (vs_mid) return (v == VT - 1 && h >= 20) || v == 0 || (v == 1 && h < 20);
        return v < VS;
    endfunction

    // one generator pixel; in slow mode followed by three disabled cycles
    task automatic step();
        logic [11:0] xh, yh;
        HSYNC = !(gh < hs_w);
        VSYNC = !vs_low(gv, gh);
        pixel_enable = 1'b1;
        @(posedge clk); #1;
        lv = gv; lh = gh;
        if (sync_error) n_err++;
        if (frame_start) n_fs++;
        if (slow) begin
            xh = X; yh = Y;
            pixel_enable = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (X != xh || Y != yh) hold_bad++;
            end
        end
        gh++;
        if (gh >= ((gv == short_v) ? HT - 1 : HT)) begin
            gh = 0;
            gv = (gv + 1) % VT;
        end
    endtask

    task automatic goto_pos(input int v, input int h);
        int n = 0;
        do begin step(); n++; end while (!(lv == v && lh == h) && n < 2000);
        if (!(lv == v && lh == h)) check("goto_pos", lv * HT + lh, v * HT + h);
    endtask

    task automatic run_to_fs(input string name);
        int n = 0;
        do begin step(); n++; end while (!frame_start && n < 2000);
        check(name, frame_start, 1);
    endtask

    task automatic relock(input string tag);
        run_to_fs({tag, "_fs1"});
        check({tag, "_fs_pos"}, lv * HT + lh, 0);
        check({tag, "_lock1"}, locked, 0);
        run_to_fs({tag, "_fs2"});
        check({tag, "_lock2"}, locked, 0);
        run_to_fs({tag, "_fs3"});
        check({tag, "_lock3"}, locked, 1);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 12; i++) begin
            goto_pos(vecs[i].v, vecs[i].h);
            check($sformatf("%s_x%0d", tag, i), X, vecs[i].x);
            check($sformatf("%s_y%0d", tag, i), Y, vecs[i].y);
            check($sformatf("%s_de%0d", tag, i), display_enable, vecs[i].de);
        end
    endtask

    initial begin
        // {line, pixel, X, Y, display_enable} in a locked frame; active window is pixels 10..33, lines 5..16
        vecs[0]  = '{0, 15, 5, 0, 0};
        vecs[1]  = '{4, 10, 0, 0, 0};
        vecs[2]  = '{5, 9, 0, 0, 0};
        vecs[3]  = '{5, 10, 0, 0, 1};
        vecs[4]  = '{5, 11, 1, 0, 1};
        vecs[5]  = '{7, 20, 10, 2, 1};
        vecs[6]  = '{10, 33, 23, 5, 1};
        vecs[7]  = '{10, 34, 0, 5, 0};
        vecs[8]  = '{16, 33, 23, 11, 1};
        vecs[9]  = '{17, 10, 0, 0, 0};
        vecs[10] = '{17, 20, 10, 0, 0};
        vecs[11] = '{19, 39, 0, 0, 0};

        reset = 1'b1; pixel_enable = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", X, 0);
        check("rst_y", Y, 0);
        check("rst_de", display_enable, 0);
        check("rst_fs", frame_start, 0);
        check("rst_lock", locked, 0);
        check("rst_err", sync_error, 0);
`ifdef SYNC_ERR_COUNT_EN
        check("rst_errcnt", err_count, 0);
`endif
        reset = 1'b0;

        // nominal timing: lock at the third frame start, then the active-area table
        n_err = 0;
        relock("nom");
        run_table("full");
        run_to_fs("nom_fs4");
        check("nom_lock4", locked, 1);
        check("nom_errs", n_err, 0);

        // one 39-pixel line while locked
        goto_pos(2, HT - 1);
        short_v = 3;
        goto_pos(3, HT - 2);
        check("short_pre_lock", locked, 1);
        check("short_pre_err", sync_error, 0);
        step();
        short_v = -1;
        check("short_err", sync_error, 1);
        check("short_lock", locked, 0);
        relock("short");

        // reset in the middle of a locked active line
        goto_pos(8, 20);
        check("mid_de", display_enable, 1);
        check("mid_x", X, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_x", X, 0);
        check("mid_rst_y", Y, 0);
        check("mid_rst_de", display_enable, 0);
        check("mid_rst_lock", locked, 0);
        relock("rst");

        // HSYNC low one pixel short on every line
        goto_pos(VT - 1, HT - 1);
        hs_w = HS - 1;
        goto_pos(0, HS - 2);
        check("hw_pre_err", sync_error, 0);
        step();
        check("hw_err", sync_error, 1);
        check("hw_lock", locked, 0);
        goto_pos(VT - 1, HT - 1);
        n_err = 0;
        goto_pos(VT - 1, HT - 1);
        check("hw_err_per_frame", n_err, VT);
        check("hw_nolock", locked, 0);
        hs_w = HS;
        relock("hw");

        // VSYNC falling mid-line: frame start waits for the next HSYNC edge
        goto_pos(17, HT - 1);
        vs_mid = 1'b1;
        n_err = 0;
        goto_pos(VT - 1, 30);
        check("vmid_pending_fs", frame_start, 0);
        run_to_fs("vmid_fs");
        check("vmid_fs_pos", lv * HT + lh, 0);
        check("vmid_lock", locked, 1);
        run_to_fs("vmid_fs2");
        check("vmid_lock2", locked, 1);
        check("vmid_errs", n_err, 0);
        goto_pos(5, 0);
        vs_mid = 1'b0;

        // one pixel strobe in four
        goto_pos(VT - 1, HT - 1);
        slow = 1'b1;
        run_table("slow");
        slow = 1'b0;
        check("slow_hold", hold_bad, 0);
        check("slow_lock", locked, 1);

`ifdef SYNC_ERR_COUNT_EN
        check("ec_locked", err_count, 0);
        goto_pos(VT - 1, HT - 1);
        hs_w = HS - 1;
        goto_pos(2, HT - 1);
        hs_w = HS;
        check("ec_three", err_count, 3);
        relock("ec");
        check("ec_cleared", err_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
